// File: rtl/dv_position_monitor.sv
// rtl/dv_position_monitor.sv - debounces valve/bypass feedback and supervises per-valve settle, drift and timeout faults
module dv_position_monitor #(
  parameter int SETTLE_MS    = 200,
  parameter int DEBOUNCE_CNT = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       strb_ms,
  input  logic [5:0] valve_cmd,
  input  logic [5:0] valve_states,
  input  logic       bypass_state,
  input  logic       fault_clear,
  output logic [5:0] in_position,
  output logic [5:0] valve_fault,
  output logic [5:0] fault_drift,
  output logic       fault_any,
  output logic       bypass_confirmed
);

  localparam int TW = $clog2(SETTLE_MS + 1);
  localparam logic [3:0]    CNT_MAX = 4'(DEBOUNCE_CNT);
  localparam logic [TW-1:0] TMR_MAX = TW'(SETTLE_MS - 1);

  typedef enum logic [1:0] {S_MOVING, S_STABLE, S_FAULT} state_t;

  logic [6:0]       r_last, r_deb;
  logic [6:0][3:0]  r_cnt;
  logic [5:0]       r_cmd_q, r_drift;
  state_t           r_state [6];
  logic [TW-1:0]    r_timer [6];

  logic [6:0]       w_raw, w_last_nxt, w_deb_nxt;
  logic [6:0][3:0]  w_cnt_nxt;
  logic [5:0]       w_edge, w_drift_nxt, w_in_pos;
  state_t           w_state_nxt [6];
  logic [TW-1:0]    w_timer_nxt [6];
  logic             w_tick;

  assign w_tick = strb_ms & enable;
  assign w_raw  = {bypass_state, valve_states};
  assign w_edge = valve_cmd ^ r_cmd_q;

  // Bit 6 is the bypass flag; it shares the debounce but has no FSM.
  always_comb begin
    w_last_nxt = r_last;
    w_cnt_nxt  = r_cnt;
    w_deb_nxt  = r_deb;
    if (w_tick) begin
      for (int i = 0; i < 7; i++) begin
        if (w_raw[i] != r_last[i]) begin
          w_last_nxt[i] = w_raw[i];
          w_cnt_nxt[i]  = 4'd1;
        end else if (r_cnt[i] < CNT_MAX) begin
          w_cnt_nxt[i] = r_cnt[i] + 4'd1;
        end
        if (w_cnt_nxt[i] == CNT_MAX) w_deb_nxt[i] = w_raw[i];
      end
    end
  end

  always_comb begin
    w_drift_nxt = r_drift;
    for (int i = 0; i < 6; i++) begin
      w_state_nxt[i] = r_state[i];
      w_timer_nxt[i] = r_timer[i];
      if (r_state[i] == S_FAULT) begin
        if (fault_clear) begin
          w_state_nxt[i] = S_MOVING;
          w_timer_nxt[i] = '0;
          w_drift_nxt[i] = 1'b0;
        end
      end else if (w_edge[i]) begin
        w_state_nxt[i] = S_MOVING;
        w_timer_nxt[i] = '0;
      end else if (w_tick) begin
        if (r_state[i] == S_MOVING) begin
          if (r_deb[i] == r_cmd_q[i]) begin
            w_state_nxt[i] = S_STABLE;
          end else if (r_timer[i] == TMR_MAX) begin
            w_state_nxt[i] = S_FAULT;
            w_drift_nxt[i] = 1'b0;
          end else begin
            w_timer_nxt[i] = r_timer[i] + 1'b1;
          end
        end else if (r_deb[i] != r_cmd_q[i]) begin
          w_state_nxt[i] = S_FAULT;
          w_drift_nxt[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last  <= '0;
      r_deb   <= '0;
      r_cnt   <= '0;
      r_cmd_q <= '0;
      r_drift <= '0;
      for (int i = 0; i < 6; i++) begin
        r_state[i] <= S_MOVING;
        r_timer[i] <= '0;
      end
    end else if (enable) begin
      r_last  <= w_last_nxt;
      r_deb   <= w_deb_nxt;
      r_cnt   <= w_cnt_nxt;
      r_cmd_q <= valve_cmd;
      r_drift <= w_drift_nxt;
      for (int i = 0; i < 6; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_timer[i] <= w_timer_nxt[i];
      end
    end
  end

  always_comb begin
    w_in_pos    = '0;
    valve_fault = '0;
    for (int i = 0; i < 6; i++) begin
      w_in_pos[i]    = (r_state[i] == S_STABLE);
      valve_fault[i] = (r_state[i] == S_FAULT);
    end
  end

  assign in_position      = w_in_pos;
  assign fault_drift      = r_drift;
  assign fault_any        = |valve_fault;
  assign bypass_confirmed = r_deb[6] & (&w_in_pos);

endmodule

// File: tb/tb_dv_position_monitor.sv
// tb/tb_dv_position_monitor.sv - directed and random checks of dv_position_monitor against a behavioural model
module tb_dv_position_monitor;

  localparam int SETTLE = 10;
  localparam int DEB    = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1, enable = 1'b1, strb_ms = 1'b0;
  logic [5:0] valve_cmd = '0, valve_states = '0;
  logic       bypass_state = 1'b0, fault_clear = 1'b0;
  logic [5:0] in_position, valve_fault, fault_drift;
  logic       fault_any, bypass_confirmed;

  int total = 0, bad = 0, phase = 0;

  dv_position_monitor #(.SETTLE_MS(SETTLE), .DEBOUNCE_CNT(DEB)) dut (
    .clk(clk), .reset(reset), .enable(enable), .strb_ms(strb_ms),
    .valve_cmd(valve_cmd), .valve_states(valve_states), .bypass_state(bypass_state),
    .fault_clear(fault_clear), .in_position(in_position), .valve_fault(valve_fault),
    .fault_drift(fault_drift), .fault_any(fault_any), .bypass_confirmed(bypass_confirmed)
  );

  always #5 clk = ~clk;

  // Model: mode 0 moving, 1 in position, 2 faulted; debounce = last DEB tick samples all equal.
  int         m_mode [6];
  int         m_elapsed [6];
  bit         m_drift [6];
  bit         m_deb [7];
  bit         m_hist [7][$];
  logic [5:0] m_cmd_seen;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 6; i++) begin
      m_mode[i] = 0; m_elapsed[i] = 0; m_drift[i] = 0;
    end
    for (int i = 0; i < 7; i++) begin
      m_deb[i] = 0;
      m_hist[i].delete();
    end
    m_cmd_seen = '0;
  endtask

  task automatic model_step();
    bit old_deb [7];
    bit raw [7];
    bit same;
    if (reset) begin
      model_reset();
      return;
    end
    if (!enable) return;
    for (int i = 0; i < 7; i++) begin
      old_deb[i] = m_deb[i];
      raw[i] = (i == 6) ? bypass_state : valve_states[i];
    end
    for (int i = 0; i < 6; i++) begin
      if (m_mode[i] == 2) begin
        if (fault_clear) begin
          m_mode[i] = 0; m_elapsed[i] = 0; m_drift[i] = 0;
        end
      end else if (valve_cmd[i] != m_cmd_seen[i]) begin
        m_mode[i] = 0; m_elapsed[i] = 0;
      end else if (strb_ms) begin
        if (m_mode[i] == 0) begin
          if (old_deb[i] == m_cmd_seen[i]) m_mode[i] = 1;
          else begin
            m_elapsed[i]++;
            if (m_elapsed[i] >= SETTLE) begin m_mode[i] = 2; m_drift[i] = 0; end
          end
        end else if (old_deb[i] != m_cmd_seen[i]) begin
          m_mode[i] = 2; m_drift[i] = 1;
        end
      end
    end
    if (strb_ms) begin
      for (int i = 0; i < 7; i++) begin
        m_hist[i].push_back(raw[i]);
        if (m_hist[i].size() > DEB) void'(m_hist[i].pop_front());
        same = (m_hist[i].size() == DEB);
        foreach (m_hist[i][k]) if (m_hist[i][k] != raw[i]) same = 0;
        if (same) m_deb[i] = raw[i];
      end
    end
    m_cmd_seen = valve_cmd;
  endtask

  task automatic check_all();
    logic [5:0] e_pos, e_flt, e_dr;
    for (int i = 0; i < 6; i++) begin
      e_pos[i] = (m_mode[i] == 1);
      e_flt[i] = (m_mode[i] == 2);
      e_dr[i]  = m_drift[i];
    end
    chk("in_position", 32'(in_position), 32'(e_pos));
    chk("valve_fault", 32'(valve_fault), 32'(e_flt));
    chk("fault_drift", 32'(fault_drift), 32'(e_dr));
    chk("fault_any", 32'(fault_any), 32'(|e_flt));
    chk("bypass_confirmed", 32'(bypass_confirmed), 32'(m_deb[6] & (&e_pos)));
  endtask

  task automatic cyc();
    strb_ms = (phase == 7);
    phase = (phase + 1) % 8;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic run_ticks(input int n);
    int k = 0;
    while (k < n) begin
      cyc();
      if (strb_ms && enable) k++;
    end
  endtask

  logic [5:0] stuck;

  initial begin
    model_reset();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("rst_outputs", {in_position, valve_fault, fault_drift, fault_any, bypass_confirmed}, '0);
    end
    reset = 1'b0;
    run_ticks(4);
    chk("s1_all_in_pos", 32'(in_position), 32'h3F);

    valve_cmd = 6'b100000;
    run_ticks(1);
    valve_states = 6'b100000;
    run_ticks(3);
    chk("s2_not_yet", 32'(in_position[5]), 32'd0);
    run_ticks(1);
    chk("s2_in_pos5", 32'(in_position[5]), 32'd1);
    chk("s2_no_fault", 32'(fault_any), 32'd0);

    valve_cmd = 6'b000001;
    valve_states = 6'b000000;
    run_ticks(9);
    chk("s3_before_timeout", 32'(valve_fault[0]), 32'd0);
    run_ticks(1);
    chk("s3_timeout", 32'(valve_fault[0]), 32'd1);
    chk("s3_drift0", 32'(fault_drift[0]), 32'd0);
    chk("s3_any", 32'(fault_any), 32'd1);
    valve_cmd = 6'b000000;
    fault_clear = 1'b1;
    cyc();
    fault_clear = 1'b0;
    run_ticks(2);
    chk("s3_recovered", 32'(in_position), 32'h3F);

    valve_cmd = 6'b000100;
    valve_states = 6'b000100;
    run_ticks(5);
    chk("s4_settled", 32'(in_position), 32'h3F);
    valve_states = 6'b000000;
    run_ticks(2);
    valve_states = 6'b000100;
    run_ticks(3);
    chk("s4_glitch_pos", 32'(in_position), 32'h3F);
    chk("s4_glitch_fault", 32'(fault_any), 32'd0);

    valve_states = 6'b000000;
    run_ticks(3);
    chk("s5_pre_drift", 32'(fault_any), 32'd0);
    run_ticks(1);
    chk("s5_drift_fault", 32'(valve_fault), 32'h04);
    chk("s5_drift_flag", 32'(fault_drift), 32'h04);
    valve_states = 6'b000100;
    fault_clear = 1'b1;
    cyc();
    fault_clear = 1'b0;
    run_ticks(4);
    chk("s5_reacquired", 32'(in_position[2]), 32'd1);
    chk("s5_cleared", 32'(valve_fault), 32'd0);

    valve_cmd = 6'b101010;
    valve_states = 6'b101010;
    bypass_state = 1'b1;
    run_ticks(5);
    chk("s6_bypass_on", 32'(bypass_confirmed), 32'd1);
    valve_cmd = 6'b101011;
    cyc();
    chk("s6_bypass_drop", 32'(bypass_confirmed), 32'd0);

    stuck = '0;
    for (int n = 0; n < 4000; n++) begin
      reset = ($urandom_range(0, 1499) == 0);
      enable = ($urandom_range(0, 19) != 0);
      fault_clear = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 199) == 0) valve_cmd = 6'($urandom);
      if ($urandom_range(0, 299) == 0) stuck = 6'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 15) == 0) valve_states = valve_cmd ^ stuck ^ 6'($urandom & $urandom);
      else if ($urandom_range(0, 3) == 0) valve_states = valve_cmd ^ stuck;
      if ($urandom_range(0, 99) == 0) bypass_state = ~bypass_state;
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
